pipe_hazard_ctrl: RTL and testbench
===================================

Name: pipe_hazard_ctrl

Overview:
Central stall/flush sequencer for the 5-stage pipelined processor.
- Drives the write-enable and bubble/flush controls of the PC and of the IF/ID, ID/EX, EX/MEM and MEM/WB pipeline registers.
- Detects load-use hazards and taken branches/jumps.
- Freezes the pipeline while a multi-cycle data-memory access completes, with a timeout to a sticky error state.
- Keeps a saturating stall-cycle performance counter.

Parameters:
TIMEOUT_CYCLES, 15, max MEM_WAIT cycles before entering ERR (legal range 1..2^CNT_W-1)
CNT_W, 4, width of the wait counter
PERF_W, 16, width of the stall-cycle counter

Ports:
clk  in  1  system clock, rising edge
rst_n  in  1  synchronous active-low reset
id_rs  in  5  rs field of instruction in ID
id_rt  in  5  rt field of instruction in ID
id_uses_rt  in  1  ID instruction reads rt
ex_MemRead  in  1  instruction in EX is a load
ex_writeReg  in  5  destination register of instruction in EX
branch_taken  in  1  branch resolved taken in ID
jump  in  1  jump decoded in ID
mem_access  in  1  instruction in MEM is lw/sw
mem_ready  in  1  data memory completes access this cycle
pc_write  out  1  PC update enable
if_id_write  out  1  IF/ID load enable
if_id_flush  out  1  IF/ID clear to NOP
id_ex_write  out  1  ID/EX load enable
id_ex_flush  out  1  load ID/EX with zero control (bubble)
ex_mem_write  out  1  EX/MEM load enable
mem_wb_bubble  out  1  force RegWrite=0, MemtoReg=0 into MEM/WB
mem_req  out  1  data memory request
timeout_err  out  1  sticky timeout flag
state  out  2  RUN=0, LU_STALL=1, MEM_WAIT=2, ERR=3
stall_cnt  out  PERF_W  saturating count of stall cycles

Behaviour:
- Registered state: state, wait counter cnt, timeout_err, stall_cnt. All other outputs are combinational from state and inputs (Mealy).
- Default outputs (no hazard): all *_write=1; flushes, bubble, mem_req = 0.
- rst_n low at a clock edge gives next cycle: state=RUN, cnt=0, timeout_err=0, stall_cnt=0.
- While rst_n is low, outputs are: all *_write=1, if_id_flush=1, id_ex_flush=1, mem_wb_bubble=1, mem_req=0, so the pipeline clears.
- Reset mid-MEM_WAIT or in ERR abandons the access; no mem_req in the following cycle unless RUN re-requests.
- lu_hazard = ex_MemRead & (ex_writeReg!=0) & ((ex_writeReg==id_rs) | (id_uses_rt & ex_writeReg==id_rt)).
- Priority in RUN/LU_STALL: memory wait > load-use > branch/jump.
- RUN:
  - mem_access=1 gives mem_req=1. If mem_ready=1 the access completes in the same cycle with no stall.
  - mem_access=1 with mem_ready=0: pc_write, if_id_write, id_ex_write, ex_mem_write = 0; mem_wb_bubble=1; next state MEM_WAIT, cnt=1; branch/lu ignored this cycle.
  - Else if lu_hazard: pc_write=0, if_id_write=0, id_ex_flush=1; next state LU_STALL. branch_taken/jump ignored this cycle; the branch re-resolves next cycle.
  - Else if branch_taken|jump: if_id_flush=1; state stays RUN.
- LU_STALL: lasts one cycle. Same evaluation as RUN, except lu_hazard is masked because EX holds a bubble. Next state per the RUN rules, otherwise RUN.
- MEM_WAIT:
  - mem_req=1 each cycle.
  - If mem_ready=0: freeze as above; cnt increments. If cnt==TIMEOUT_CYCLES, next state is ERR.
  - If mem_ready=1: freeze is released in that same cycle (default outputs, mem_wb_bubble=0); next state RUN, cnt=0. A ready arriving on the cycle where cnt==TIMEOUT_CYCLES wins over the timeout.
- ERR: all *_write=0, mem_wb_bubble=1, mem_req=0, timeout_err=1 (sticky). Exit only via reset.
- stall_cnt: +1 each cycle in which pc_write=0 outside reset, including ERR. Saturates at 2^PERF_W-1 with no wrap.
- Register $0 never causes a load-use stall.

Test Plan:
- Load-use: ex_MemRead=1, ex_writeReg=8, id_rs=8 -> one cycle of pc_write=0, if_id_write=0, id_ex_flush=1, state=1. Next cycle default outputs, state=0, stall_cnt=1.
- $0 and rt masking:
  - ex_writeReg=0, id_rs=0 -> no stall.
  - ex_writeReg=9, id_rt=9, id_uses_rt=0 -> no stall.
  - Same with id_uses_rt=1 -> stall.
- Branch vs load-use: branch_taken=1 together with lu_hazard -> only the stall is asserted (if_id_flush=0). Next cycle branch_taken=1 -> if_id_flush=1, pc_write=1.
- Memory wait: mem_access=1 with mem_ready low for 3 cycles, then high -> 3 cycles of freeze with mem_wb_bubble=1 and mem_req=1; release on the ready cycle; state returns to 0; stall_cnt=3.
- Timeout: TIMEOUT_CYCLES=4, mem_ready held 0 -> ERR entered after 4 wait cycles, timeout_err=1, freeze held. Reset with rst_n=0 for 1 cycle -> RUN, timeout_err=0, stall_cnt=0.
- Saturation and reset: PERF_W=4, hold ERR for 20 cycles -> stall_cnt stays 15. Assert rst_n=0 during MEM_WAIT -> next cycle state=0, mem_req=0 while mem_access=0.

Source files
------------

// File: rtl/pipe_hazard_ctrl_if.sv
// Pipeline-side hazard signals and the stall/flush controls returned to the datapath.
// The slave modport is the hazard controller; the master modport is the pipeline driving it.
interface pipe_hazard_ctrl_if #(
  parameter int unsigned PERF_W = 16
);
  logic [4:0]        id_rs;
  logic [4:0]        id_rt;
  logic              id_uses_rt;
  logic              ex_MemRead;
  logic [4:0]        ex_writeReg;
  logic              branch_taken;
  logic              jump;
  logic              mem_access;
  logic              mem_ready;
  logic              pc_write;
  logic              if_id_write;
  logic              if_id_flush;
  logic              id_ex_write;
  logic              id_ex_flush;
  logic              ex_mem_write;
  logic              mem_wb_bubble;
  logic              mem_req;
  logic              timeout_err;
  logic [1:0]        state;
  logic [PERF_W-1:0] stall_cnt;

  modport master (
    output id_rs, id_rt, id_uses_rt, ex_MemRead, ex_writeReg, branch_taken, jump,
           mem_access, mem_ready,
    input  pc_write, if_id_write, if_id_flush, id_ex_write, id_ex_flush, ex_mem_write,
           mem_wb_bubble, mem_req, timeout_err, state, stall_cnt
  );

  modport slave (
    input  id_rs, id_rt, id_uses_rt, ex_MemRead, ex_writeReg, branch_taken, jump,
           mem_access, mem_ready,
    output pc_write, if_id_write, if_id_flush, id_ex_write, id_ex_flush, ex_mem_write,
           mem_wb_bubble, mem_req, timeout_err, state, stall_cnt
  );
endinterface

// File: rtl/pipe_hazard_ctrl.sv
// Stall/flush sequencer for a 5-stage pipeline: load-use stalls, branch flushes,
// data-memory wait freeze with timeout to a sticky error, and a stall-cycle counter.
module pipe_hazard_ctrl #(
  parameter int unsigned TIMEOUT_CYCLES = 15,
  parameter int unsigned CNT_W          = 4,
  parameter int unsigned PERF_W         = 16
) (
  input logic               clk,
  input logic               rst_n,
  pipe_hazard_ctrl_if.slave bus
);

  typedef enum logic [1:0] {
    StRun     = 2'd0,
    StLuStall = 2'd1,
    StMemWait = 2'd2,
    StErr     = 2'd3
  } state_e;

  state_e            state_q, state_d;
  logic [CNT_W-1:0]  cnt_q, cnt_d;
  logic              err_q, err_d;
  logic [PERF_W-1:0] stall_cnt_q, stall_cnt_d;

  logic lu_hazard, lu_eff, mem_miss;
  logic pc_wr, if_id_wr, if_id_fl, id_ex_wr, id_ex_fl, ex_mem_wr, bubble, req;

  assign lu_hazard = bus.ex_MemRead && (bus.ex_writeReg != 5'd0) &&
                     ((bus.ex_writeReg == bus.id_rs) ||
                      (bus.id_uses_rt && (bus.ex_writeReg == bus.id_rt)));
  // EX holds a bubble during LU_STALL, so a second load-use stall would be spurious.
  assign lu_eff    = lu_hazard && (state_q == StRun);
  assign mem_miss  = bus.mem_access && !bus.mem_ready;

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_q     <= StRun;
      cnt_q       <= '0;
      err_q       <= 1'b0;
      stall_cnt_q <= '0;
    end else begin
      state_q     <= state_d;
      cnt_q       <= cnt_d;
      err_q       <= err_d;
      stall_cnt_q <= stall_cnt_d;
    end
  end

  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    err_d   = err_q;
    case (state_q)
      StRun, StLuStall: begin
        cnt_d = '0;
        if (mem_miss) begin
          state_d = StMemWait;
          cnt_d   = CNT_W'(1);
        end else if (lu_eff) begin
          state_d = StLuStall;
        end else begin
          state_d = StRun;
        end
      end
      StMemWait: begin
        if (bus.mem_ready) begin
          state_d = StRun;
          cnt_d   = '0;
        end else if (cnt_q == CNT_W'(TIMEOUT_CYCLES)) begin
          state_d = StErr;
          cnt_d   = '0;
          err_d   = 1'b1;
        end else begin
          cnt_d = cnt_q + CNT_W'(1);
        end
      end
      default: begin
        state_d = StErr;
        err_d   = 1'b1;
      end
    endcase
    stall_cnt_d = stall_cnt_q;
    if (!pc_wr && (stall_cnt_q != {PERF_W{1'b1}})) begin
      stall_cnt_d = stall_cnt_q + PERF_W'(1);
    end
  end

  always_comb begin
    pc_wr     = 1'b1;
    if_id_wr  = 1'b1;
    if_id_fl  = 1'b0;
    id_ex_wr  = 1'b1;
    id_ex_fl  = 1'b0;
    ex_mem_wr = 1'b1;
    bubble    = 1'b0;
    req       = 1'b0;
    if (!rst_n) begin
      // Flush every stage so the pipeline drains to NOPs while reset is held.
      if_id_fl = 1'b1;
      id_ex_fl = 1'b1;
      bubble   = 1'b1;
    end else begin
      case (state_q)
        StRun, StLuStall: begin
          if (bus.mem_access) begin
            req = 1'b1;
          end
          if (mem_miss) begin
            pc_wr     = 1'b0;
            if_id_wr  = 1'b0;
            id_ex_wr  = 1'b0;
            ex_mem_wr = 1'b0;
            bubble    = 1'b1;
          end else if (lu_eff) begin
            pc_wr    = 1'b0;
            if_id_wr = 1'b0;
            id_ex_fl = 1'b1;
          end else if (bus.branch_taken || bus.jump) begin
            if_id_fl = 1'b1;
          end
        end
        StMemWait: begin
          req = 1'b1;
          if (!bus.mem_ready) begin
            pc_wr     = 1'b0;
            if_id_wr  = 1'b0;
            id_ex_wr  = 1'b0;
            ex_mem_wr = 1'b0;
            bubble    = 1'b1;
          end
        end
        default: begin
          pc_wr     = 1'b0;
          if_id_wr  = 1'b0;
          id_ex_wr  = 1'b0;
          ex_mem_wr = 1'b0;
          bubble    = 1'b1;
        end
      endcase
    end
  end

  assign bus.pc_write      = pc_wr;
  assign bus.if_id_write   = if_id_wr;
  assign bus.if_id_flush   = if_id_fl;
  assign bus.id_ex_write   = id_ex_wr;
  assign bus.id_ex_flush   = id_ex_fl;
  assign bus.ex_mem_write  = ex_mem_wr;
  assign bus.mem_wb_bubble = bubble;
  assign bus.mem_req       = req;
  assign bus.timeout_err   = err_q;
  assign bus.state         = state_q;
  assign bus.stall_cnt     = stall_cnt_q;

endmodule

// File: tb/tb_pipe_hazard_ctrl.sv
// Directed bench for pipe_hazard_ctrl: a cycle-by-cycle vector table plus hand-written
// timeout, saturation and ready-at-timeout sequences.
module tb_pipe_hazard_ctrl;

  // ctl = {pc_write, if_id_write, if_id_flush, id_ex_write, id_ex_flush,
  //        ex_mem_write, mem_wb_bubble, mem_req}
  localparam logic [7:0] DEF = 8'b1101_0100;
  localparam logic [7:0] RST = 8'b1111_1110;
  localparam logic [7:0] LUS = 8'b0001_1100;
  localparam logic [7:0] BRF = 8'b1111_0100;
  localparam logic [7:0] FRZ = 8'b0000_0011;
  localparam logic [7:0] MOK = 8'b1101_0101;
  localparam logic [7:0] ERC = 8'b0000_0010;

  typedef struct {
    logic       rst;
    logic [4:0] rs;
    logic [4:0] rt;
    logic       urt;
    logic       mr;
    logic [4:0] wr;
    logic       br;
    logic       jmp;
    logic       acc;
    logic       rdy;
    logic [7:0] ctl;
    logic       err;
    logic [1:0] st;
    logic [3:0] cnt;
  } vec_t;

  logic clk;
  logic rst_n;
  int   n_tests;
  int   n_fail;
  vec_t vq[$];

  pipe_hazard_ctrl_if #(.PERF_W(4)) bus ();

  pipe_hazard_ctrl #(
    .TIMEOUT_CYCLES(4),
    .CNT_W         (4),
    .PERF_W        (4)
  ) dut (
    .clk  (clk),
    .rst_n(rst_n),
    .bus  (bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  function automatic vec_t mk(input int rst, input int rs, input int rt, input int urt,
                              input int mr, input int wr, input int br, input int jmp,
                              input int acc, input int rdy, input logic [7:0] ctl,
                              input int err, input int st, input int cnt);
    vec_t v;
    v.rst = (rst != 0);
    v.rs  = 5'(rs);
    v.rt  = 5'(rt);
    v.urt = (urt != 0);
    v.mr  = (mr != 0);
    v.wr  = 5'(wr);
    v.br  = (br != 0);
    v.jmp = (jmp != 0);
    v.acc = (acc != 0);
    v.rdy = (rdy != 0);
    v.ctl = ctl;
    v.err = (err != 0);
    v.st  = 2'(st);
    v.cnt = 4'(cnt);
    return v;
  endfunction

  // Drive one cycle's inputs at the falling edge, then check settled outputs 1ns later.
  task automatic run_vec(input string name, input vec_t v);
    logic [7:0] ctl;
    @(negedge clk);
    rst_n            = v.rst;
    bus.id_rs        = v.rs;
    bus.id_rt        = v.rt;
    bus.id_uses_rt   = v.urt;
    bus.ex_MemRead   = v.mr;
    bus.ex_writeReg  = v.wr;
    bus.branch_taken = v.br;
    bus.jump         = v.jmp;
    bus.mem_access   = v.acc;
    bus.mem_ready    = v.rdy;
    #1;
    ctl = {bus.pc_write, bus.if_id_write, bus.if_id_flush, bus.id_ex_write, bus.id_ex_flush,
           bus.ex_mem_write, bus.mem_wb_bubble, bus.mem_req};
    n_tests++;
    if (ctl !== v.ctl || bus.timeout_err !== v.err || bus.state !== v.st ||
        bus.stall_cnt !== v.cnt) begin
      n_fail++;
      $display("FAIL %s: got ctl=%b err=%b st=%0d cnt=%0d, want ctl=%b err=%b st=%0d cnt=%0d",
               name, ctl, bus.timeout_err, bus.state, bus.stall_cnt,
               v.ctl, v.err, v.st, v.cnt);
    end
  endtask

  // Memory-only cycle: all hazard inputs quiet.
  task automatic mem_cyc(input string name, input int rst, input int acc, input int rdy,
                         input logic [7:0] ctl, input int err, input int st, input int cnt);
    run_vec(name, mk(rst, 0, 0, 0, 0, 0, 0, 0, acc, rdy, ctl, err, st, cnt));
  endtask

  initial begin
    n_tests          = 0;
    n_fail           = 0;
    rst_n            = 1'b0;
    bus.id_rs        = '0;
    bus.id_rt        = '0;
    bus.id_uses_rt   = 1'b0;
    bus.ex_MemRead   = 1'b0;
    bus.ex_writeReg  = '0;
    bus.branch_taken = 1'b0;
    bus.jump         = 1'b0;
    bus.mem_access   = 1'b0;
    bus.mem_ready    = 1'b0;

    //                rst rs rt urt mr wr br jmp acc rdy  ctl  err st cnt
    vq.push_back(mk(0, 0, 0, 0, 0, 0, 0, 0, 0, 0, RST, 0, 0, 0)); // reset outputs
    vq.push_back(mk(1, 0, 0, 0, 0, 0, 0, 0, 0, 0, DEF, 0, 0, 0)); // idle
    vq.push_back(mk(1, 8, 0, 0, 1, 8, 0, 0, 0, 0, LUS, 0, 0, 0)); // load-use on rs
    vq.push_back(mk(1, 0, 0, 0, 0, 0, 0, 0, 0, 0, DEF, 0, 1, 1)); // LU_STALL, one stall
    vq.push_back(mk(1, 0, 0, 0, 0, 0, 0, 0, 0, 0, DEF, 0, 0, 1));
    vq.push_back(mk(1, 0, 0, 0, 1, 0, 0, 0, 0, 0, DEF, 0, 0, 1)); // $0 never stalls
    vq.push_back(mk(1, 1, 9, 0, 1, 9, 0, 0, 0, 0, DEF, 0, 0, 1)); // rt not read
    vq.push_back(mk(1, 1, 9, 1, 1, 9, 0, 0, 0, 0, LUS, 0, 0, 1)); // rt read -> stall
    vq.push_back(mk(1, 0, 0, 0, 0, 0, 0, 0, 0, 0, DEF, 0, 1, 2));
    vq.push_back(mk(1, 5, 0, 0, 1, 5, 1, 0, 0, 0, LUS, 0, 0, 2)); // stall beats branch
    vq.push_back(mk(1, 0, 0, 0, 0, 0, 1, 0, 0, 0, BRF, 0, 1, 3)); // branch re-resolves
    vq.push_back(mk(1, 0, 0, 0, 0, 0, 0, 1, 0, 0, BRF, 0, 0, 3)); // jump flush
    vq.push_back(mk(1, 7, 0, 0, 1, 7, 0, 0, 0, 0, LUS, 0, 0, 3));
    vq.push_back(mk(1, 7, 0, 0, 1, 7, 0, 0, 0, 0, DEF, 0, 1, 4)); // lu masked in LU_STALL
    vq.push_back(mk(1, 0, 0, 0, 0, 0, 0, 0, 0, 0, DEF, 0, 0, 4));
    vq.push_back(mk(0, 0, 0, 0, 0, 0, 0, 0, 0, 0, RST, 0, 0, 4)); // clear counter
    vq.push_back(mk(1, 0, 0, 0, 0, 0, 0, 0, 0, 0, DEF, 0, 0, 0));
    vq.push_back(mk(1, 0, 0, 0, 0, 0, 0, 0, 1, 1, MOK, 0, 0, 0)); // ready access, no stall
    vq.push_back(mk(1, 8, 0, 0, 1, 8, 1, 0, 1, 0, FRZ, 0, 0, 0)); // mem wait beats lu/branch
    vq.push_back(mk(1, 0, 0, 0, 0, 0, 0, 0, 1, 0, FRZ, 0, 2, 1));
    vq.push_back(mk(1, 0, 0, 0, 0, 0, 0, 0, 1, 0, FRZ, 0, 2, 2));
    vq.push_back(mk(1, 0, 0, 0, 0, 0, 0, 0, 1, 1, MOK, 0, 2, 3)); // release on ready
    vq.push_back(mk(1, 0, 0, 0, 0, 0, 0, 0, 0, 0, DEF, 0, 0, 3));
    vq.push_back(mk(1, 0, 0, 0, 0, 0, 0, 0, 1, 0, FRZ, 0, 0, 3));
    vq.push_back(mk(1, 0, 0, 0, 0, 0, 0, 0, 1, 0, FRZ, 0, 2, 4));
    vq.push_back(mk(0, 0, 0, 0, 0, 0, 0, 0, 1, 0, RST, 0, 2, 5)); // reset mid-MEM_WAIT
    vq.push_back(mk(1, 0, 0, 0, 0, 0, 0, 0, 0, 0, DEF, 0, 0, 0)); // access abandoned

    foreach (vq[i]) run_vec($sformatf("vec%0d", i), vq[i]);

    // Timeout: RUN miss plus four MEM_WAIT cycles, then ERR.
    mem_cyc("to_run", 1, 1, 0, FRZ, 0, 0, 0);
    for (int i = 1; i <= 4; i++) mem_cyc($sformatf("to_wait%0d", i), 1, 1, 0, FRZ, 0, 2, i);
    mem_cyc("to_err", 1, 1, 0, ERC, 1, 3, 5);
    for (int k = 0; k < 20; k++) begin
      mem_cyc($sformatf("sat%0d", k), 1, 1, 0, ERC, 1, 3, (6 + k > 15) ? 15 : 6 + k);
    end
    mem_cyc("err_rst", 0, 0, 0, RST, 1, 3, 15);
    mem_cyc("err_exit", 1, 0, 0, DEF, 0, 0, 0);

    // Ready on the cycle the wait counter hits the limit must win over the timeout.
    mem_cyc("rw_run", 1, 1, 0, FRZ, 0, 0, 0);
    for (int i = 1; i <= 3; i++) mem_cyc($sformatf("rw_wait%0d", i), 1, 1, 0, FRZ, 0, 2, i);
    mem_cyc("rw_ready", 1, 1, 1, MOK, 0, 2, 4);
    mem_cyc("rw_after", 1, 0, 0, DEF, 0, 0, 4);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
